// File: rtl/free_list_bank_if.sv
// Free list handshake bundle: enqueue of freed PR tags, dequeue of allocated tags.
// master: rename/commit side driving enq and deq_ready; slave: the free list bank.
interface free_list_bank_if #(
  parameter int LOG_PR_COUNT                  = 7,
  parameter int LOG_FREE_LIST_LENGTH_PER_BANK = 5
);
  logic                                   enq_valid;
  logic [LOG_PR_COUNT-1:0]                enq_PR;
  logic                                   enq_ready;
  logic                                   deq_valid;
  logic [LOG_PR_COUNT-1:0]                deq_PR;
  logic                                   deq_ready;
  logic [LOG_FREE_LIST_LENGTH_PER_BANK:0] count;
  logic                                   below_lower;
  logic                                   above_upper;
  logic                                   overflow_err;

  modport master (
    output enq_valid, enq_PR, deq_ready,
    input  enq_ready, deq_valid, deq_PR,
    input  count, below_lower, above_upper, overflow_err
  );

  modport slave (
    input  enq_valid, enq_PR, deq_ready,
    output enq_ready, deq_valid, deq_PR,
    output count, below_lower, above_upper, overflow_err
  );
endinterface

// File: rtl/free_list_bank.sv
// Per-bank circular free list of PR tags for rename; CLK/RST plain, rest via fl (slave).
// Ports: fl carries enq/deq handshakes, count, thresholds, sticky overflow_err.
// Optional macro FREE_LIST_BYPASS_EN: when empty, an enqueued tag passes straight to deq.
module free_list_bank #(
  parameter int FREE_LIST_LENGTH_PER_BANK     = 32,
  parameter int LOG_FREE_LIST_LENGTH_PER_BANK = 5,
  parameter int LOG_PR_COUNT                  = 7,
  parameter int PRF_BANK_COUNT                = 4,
  parameter int BANK_INDEX                    = 0,
  parameter int AR_COUNT                      = 32,
  parameter int FREE_LIST_LOWER_THRESHOLD     = 8,
  parameter int FREE_LIST_UPPER_THRESHOLD     = 24
) (
  input logic           CLK,
  input logic           RST,
  free_list_bank_if.slave fl
);
  localparam int LG   = LOG_FREE_LIST_LENGTH_PER_BANK;
  localparam int LEN  = FREE_LIST_LENGTH_PER_BANK;
  localparam int INIT = LEN - AR_COUNT / PRF_BANK_COUNT;

  typedef logic [LG:0]             ptr_t;
  typedef logic [LOG_PR_COUNT-1:0] tag_t;

  tag_t mem [LEN];
  ptr_t head, tail, cnt;
  ptr_t head_n, tail_n;
  logic ovf;
  logic full, empty;
  logic enq_fire, deq_fire;
  logic handoff;

  assign full  = (head[LG] != tail[LG]) &&
                 (head[LG-1:0] == tail[LG-1:0]);
  assign empty = (head == tail);

  // At full a same-cycle dequeue frees the slot the enqueue writes,
  // so deq_ready also opens the enqueue side.
  assign fl.enq_ready = !full || fl.deq_ready;
  assign deq_fire     = !empty && fl.deq_ready;

`ifdef FREE_LIST_BYPASS_EN
  assign handoff      = empty && fl.enq_valid && fl.deq_ready;
  assign fl.deq_valid = !empty || fl.enq_valid;
  assign fl.deq_PR    = empty ? fl.enq_PR
                              : mem[head[LG-1:0]];
`else
  assign handoff      = 1'b0;
  assign fl.deq_valid = !empty;
  assign fl.deq_PR    = mem[head[LG-1:0]];
`endif

  assign enq_fire = fl.enq_valid && fl.enq_ready && !handoff;

  always_comb begin
    head_n = head;
    tail_n = tail;
    if (deq_fire) head_n = head + ptr_t'(1);
    if (enq_fire) tail_n = tail + ptr_t'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < LEN; i++) begin
        if (i < INIT)
          mem[i] <= tag_t'(PRF_BANK_COUNT *
                    (AR_COUNT / PRF_BANK_COUNT + i) + BANK_INDEX);
        else
          mem[i] <= '0;
      end
      head <= '0;
      tail <= ptr_t'(INIT);
      cnt  <= ptr_t'(INIT);
      ovf  <= 1'b0;
    end else begin
      if (enq_fire) mem[tail[LG-1:0]] <= fl.enq_PR;
      head <= head_n;
      tail <= tail_n;
      cnt  <= tail_n - head_n;
      if (fl.enq_valid && !fl.enq_ready) ovf <= 1'b1;
    end
  end

  assign fl.count        = cnt;
  assign fl.overflow_err = ovf;
  assign fl.below_lower  = cnt < ptr_t'(FREE_LIST_LOWER_THRESHOLD);
  assign fl.above_upper  = cnt > ptr_t'(FREE_LIST_UPPER_THRESHOLD);
endmodule

// File: tb/tb_free_list_bank.sv
// Randomized and directed bench for free_list_bank (BANK_INDEX=1) against a queue model.
// Ports: none; instantiates free_list_bank_if and the DUT.
module tb_free_list_bank;
  localparam int BANK = 1;
  localparam int CAP  = 32;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  free_list_bank_if #(
    .LOG_PR_COUNT(7),
    .LOG_FREE_LIST_LENGTH_PER_BANK(5)
  ) fl ();

  free_list_bank #(
    .BANK_INDEX(BANK)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .fl (fl.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int q[$];
  bit m_ovf;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d @%0t", tag, got, exp, $time);
    end
  endtask

  // Reset contents: the free PRs of this bank above the architectural range.
  task automatic model_reset();
    q.delete();
    for (int i = 0; i < CAP - 32 / 4; i++) q.push_back(4 * (8 + i) + BANK);
    m_ovf = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"}, int'(fl.count), q.size());
    check({tag, ".below"}, int'(fl.below_lower), int'(q.size() < 8));
    check({tag, ".above"}, int'(fl.above_upper), int'(q.size() > 24));
    check({tag, ".ovf"}, int'(fl.overflow_err), int'(m_ovf));
  endtask

  // One clock: drive just after posedge, check at negedge, update model at posedge.
  task automatic step(input bit ev, input int pr, input bit dr, input string tag);
    bit mv, mr, efire, dfire;
    int mpr;
    fl.enq_valid = ev;
    fl.enq_PR    = 7'(pr);
    fl.deq_ready = dr;
    @(negedge CLK);
    check_state(tag);
    mr = (q.size() < CAP) || dr;
`ifdef FREE_LIST_BYPASS_EN
    mv  = (q.size() > 0) || ev;
    mpr = (q.size() > 0) ? q[0] : pr;
`else
    mv  = q.size() > 0;
    mpr = (q.size() > 0) ? q[0] : -1;
`endif
    check({tag, ".enq_ready"}, int'(fl.enq_ready), int'(mr));
    check({tag, ".deq_valid"}, int'(fl.deq_valid), int'(mv));
    if (mv) check({tag, ".deq_PR"}, int'(fl.deq_PR), mpr);
    dfire = dr && q.size() > 0;
    efire = ev && mr;
`ifdef FREE_LIST_BYPASS_EN
    if (q.size() == 0 && ev && dr) efire = 1'b0;
`endif
    if (ev && !mr) m_ovf = 1'b1;
    @(posedge CLK);
    if (dfire) void'(q.pop_front());
    if (efire) q.push_back(pr);
    #1;
  endtask

  function automatic int rtag();
    return $urandom_range(0, 31) * 4 + BANK;
  endfunction

  task automatic do_reset();
    RST = 1'b1;
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    check_state("in_reset");
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    fl.enq_valid = 1'b0;
    fl.enq_PR    = '0;
    fl.deq_ready = 1'b0;
    do_reset();
    step(0, 0, 0, "reset");
    check("reset.deq_PR_abs", int'(fl.deq_PR), 33);

    for (int i = 0; i < 24; i++) step(0, 0, 1, "drain");
    step(0, 0, 0, "empty");
    check("empty.count_abs", int'(fl.count), 0);

    step(1, 5, 0, "enq5");
    step(1, 9, 0, "enq9");
    step(1, 13, 0, "enq13");
    for (int i = 0; i < 3; i++) step(0, 0, 1, "deq3");
    step(0, 0, 0, "empty2");

    step(1, 17, 1, "empty_both");
    step(0, 0, 0, "after_both");
    step(0, 0, 1, "deq17");

    do_reset();
    for (int i = 0; i < 8; i++) step(1, 4 * i + BANK, 0, "fill");
    step(1, 125, 0, "overflow");
    step(0, 0, 0, "full_hold");
    check("full.ovf_abs", int'(fl.overflow_err), 1);
    for (int i = 0; i < 6; i++) step(1, rtag(), 1, "full_both");
    for (int i = 0; i < 22; i++) step(0, 0, 1, "to10");
    step(0, 0, 0, "at10");
    check("at10.count_abs", int'(fl.count), 10);

    #2;
    RST = 1'b1;
    model_reset();
    #1;
    check("async.count", int'(fl.count), 24);
    check("async.deq_PR", int'(fl.deq_PR), 32 + BANK);
    check("async.ovf", int'(fl.overflow_err), 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel = $urandom_range(0, 99);
      step($urandom_range(0, 99) < 55, rtag(), sel < 50, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
